// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter giving NPORTS processor requesters and the testbench access to one RAM port.
// Define RAM_ARB_TIMEOUT_EN to build the OWN-state watchdog (limit TIMEOUT cycles, sticky timeout_err).
module ram_port_arbiter #(
  parameter int NPORTS  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     tbCTRL,
  input  logic                     tb_ren,
  input  logic                     tb_wen,
  input  logic [ADDR_W-1:0]        tb_addr,
  input  logic [DATA_W-1:0]        tb_store,
  input  logic [NPORTS-1:0]        req_ren,
  input  logic [NPORTS-1:0]        req_wen,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  input  logic [NPORTS*DATA_W-1:0] req_store,
  output logic [NPORTS-1:0]        req_wait,
  output logic [DATA_W-1:0]        req_load,
  output logic [NPORTS-1:0]        grant,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_store,
  input  logic [DATA_W-1:0]        ram_load,
  input  logic [1:0]               ram_state,
  output logic                     timeout_err
);

  localparam int          IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned NP = NPORTS;

  typedef enum logic [1:0] {IDLE, OWN, TB} state_t;

  state_t            state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     pick;
  logic              found;
  logic              done;
  logic              wd_hit;
  logic [NPORTS-1:0] request;

  assign request  = req_ren | req_wen;
  // ERROR ends the transaction exactly like ACCESS
  assign done     = (state == OWN) && ((ram_state == 2'd2) || (ram_state == 2'd3));
  // grant is one-hot owner while in OWN, so it doubles as the completion mask
  assign req_wait = request & ~(done ? grant : '0);
  assign req_load = ram_load;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] p);
    return (int'(p) == NPORTS - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = (32'(rr_ptr) + k) % NP;
      if (!found && request[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // counter is held at zero outside OWN, so every entry to OWN starts from 0
  assign wd_hit = done ? 1'b0 : ((state == OWN) && request[owner] && (wd_cnt == 32'(TIMEOUT - 1)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state == OWN) ? wd_cnt + 32'd1 : '0;
      if (wd_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tbCTRL) begin
            state <= TB;
          end else if (found) begin
            state <= OWN;
            owner <= pick;
            grant <= NPORTS'(1) << pick;
          end
        end
        OWN: begin
          if (done || wd_hit) begin
            state  <= IDLE;
            rr_ptr <= next_idx(owner);
            grant  <= '0;
          end else if (!request[owner]) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        TB: begin
          if (!tbCTRL) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state)
      OWN: begin
        ram_ren   = req_ren[owner];
        ram_wen   = req_wen[owner];
        ram_addr  = req_addr[owner*ADDR_W +: ADDR_W];
        ram_store = req_store[owner*DATA_W +: DATA_W];
      end
      TB: begin
        ram_ren   = tb_ren;
        ram_wen   = tb_wen;
        ram_addr  = tb_addr;
        ram_store = tb_store;
      end
      default: ;
    endcase
  end

endmodule
